// File: rtl/apb_master_ctrl.sv
// APB master controller: converts single-beat host requests into APB SETUP/ACCESS
// sequences over two slaves, decoded by the top address bit, with an ACCESS-phase timeout.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               pready_s;
  logic [DATA_W-1:0]  prdata_s;

  // Only the slave addressed by the latched PADDR contributes ready/data.
  always_comb begin
    pready_s = 1'b0;
    prdata_s = {DATA_W{1'b0}};
    if (PADDR[ADDR_W-1]) begin
      pready_s = PREADY2;
      prdata_s = PRDATA2;
    end else begin
      pready_s = PREADY1;
      prdata_s = PRDATA1;
    end
  end

  assign req_ready = (state_r == IDLE) && PRESETn;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= {ADDR_W{1'b0}};
      PWDATA    <= {DATA_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            PWRITE  <= req_write;
            PADDR   <= req_addr;
            PWDATA  <= req_wdata;
            PSEL1   <= ~req_addr[ADDR_W-1];
            PSEL2   <= req_addr[ADDR_W-1];
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (pready_s) begin
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? {DATA_W{1'b0}} : prdata_s;
            state_r   <= IDLE;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            // The last permitted wait cycle has elapsed: abort with an error response.
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= {DATA_W{1'b0}};
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          PSEL1   <= 1'b0;
          PSEL2   <= 1'b0;
          PENABLE <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
